// File: rtl/dmem_wbuf_pkg.sv
// Shared declarations for the data-memory write buffer: default sizes,
// the buffer entry layout and the drain decision helper.
// Optional feature macro: DMEM_WBUF_COALESCE_EN (store coalescing).
package dmem_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_MEM_WORDS = 64;
  localparam int DEF_IDXW      = $clog2(DEF_MEM_WORDS);

  // Entry layout for the default configuration; wbuf_fifo mirrors this
  // layout with its own parameterised widths.
  typedef struct packed {
    logic [DEF_IDXW-1:0]  idx;
    logic [DEF_WIDTH-1:0] data;
  } wbuf_entry_t;

  // Head retires when the buffer is non-empty and either the RAM port is
  // free (no store this cycle) or the buffer is full and the incoming store
  // needs a slot (a coalescing store needs none).
  function automatic logic wbufDrainCond(input logic nonEmpty,
                                         input logic storeReq,
                                         input logic full,
                                         input logic coalesceHit);
    return nonEmpty && (!storeReq || (full && !coalesceHit));
  endfunction

endpackage

// File: rtl/dmem_wbuf_if.sv
// Memory-stage bus between the core's Execute/Memory register and dmem_wbuf.
interface dmem_wbuf_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                       memWriteM;
  logic [WIDTH-1:0]           aluResultM;
  logic [WIDTH-1:0]           writeData;
  logic [WIDTH-1:0]           readDataM;
  logic [$clog2(DEPTH+1)-1:0] wbufCount;
  logic                       wbufEmpty;

  modport master (
    output memWriteM, aluResultM, writeData,
    input  readDataM, wbufCount, wbufEmpty
  );

  modport slave (
    input  memWriteM, aluResultM, writeData,
    output readDataM, wbufCount, wbufEmpty
  );
endinterface

// File: rtl/dmem_wbuf_fifo.sv
// Circular posted-store buffer: entry array, head/tail/count, youngest-match
// search for forwarding and the drain decision.
// Optional feature macro: DMEM_WBUF_COALESCE_EN (store coalescing).
module wbuf_fifo
  import dmem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDXW  = DEF_IDXW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrEn,
  input  logic [IDXW-1:0]  wrIdx,
  input  logic [WIDTH-1:0] wrData,
  input  logic [IDXW-1:0]  rdIdx,
  output logic             rdHit,
  output logic [WIDTH-1:0] rdData,
  output logic             drain,
  output logic [IDXW-1:0]  headIdx,
  output logic [WIDTH-1:0] headData,
  output logic             full,
  output logic [CW-1:0]    count
);

  typedef struct packed {
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t          entries [DEPTH];
  logic [PW-1:0]   headPtr;
  logic [PW-1:0]   tailPtr;
  logic [PW-1:0]   rdPos;
  logic            coalHit;
  logic            alloc;

  // Youngest matching entry for the load index: scan oldest to youngest so
  // the last match found wins.
  always_comb begin
    rdHit = 1'b0;
    rdPos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count && entries[headPtr + PW'(k)].idx == rdIdx) begin
        rdHit = 1'b1;
        rdPos = headPtr + PW'(k);
      end
    end
    rdData = entries[rdPos].data;
  end

`ifdef DMEM_WBUF_COALESCE_EN
  logic          wrHit;
  logic [PW-1:0] wrPos;

  // Youngest matching entry for the store index, target of an in-place merge.
  always_comb begin
    wrHit = 1'b0;
    wrPos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count && entries[headPtr + PW'(k)].idx == wrIdx) begin
        wrHit = 1'b1;
        wrPos = headPtr + PW'(k);
      end
    end
  end

  assign coalHit = wrEn && wrHit;
`else
  assign coalHit = 1'b0;
`endif

  assign full     = (count == CW'(DEPTH));
  assign alloc    = wrEn && !coalHit;
  assign drain    = wbufDrainCond(count != '0, wrEn, full, coalHit);
  assign headIdx  = entries[headPtr].idx;
  assign headData = entries[headPtr].data;

  // Pointer and occupancy bookkeeping; enqueue and drain may share an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (alloc) tailPtr <= tailPtr + 1'b1;
      if (drain) headPtr <= headPtr + 1'b1;
      count <= count + CW'(alloc) - CW'(drain);
    end
  end

  // Entry storage: allocate at tail, or merge into the matching entry.
`ifdef DMEM_WBUF_COALESCE_EN
  always_ff @(posedge clk) begin
    if (alloc)        entries[tailPtr]    <= '{idx: wrIdx, data: wrData};
    else if (coalHit) entries[wrPos].data <= wrData;
  end
`else
  always_ff @(posedge clk) begin
    if (alloc) entries[tailPtr] <= '{idx: wrIdx, data: wrData};
  end
`endif

endmodule

// File: rtl/dmem_wbuf.sv
// Data-memory stage with a posted-store write buffer in front of a
// single-write-port word RAM; loads are combinational with forwarding.
// Optional feature macro: DMEM_WBUF_COALESCE_EN (store coalescing).
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  localparam int IDXW     = $clog2(MEM_WORDS),
  localparam int CW       = $clog2(DEPTH+1)
) (
  input logic         clk,
  input logic         reset,
  dmem_wbuf_if.slave  bus
);

  logic [WIDTH-1:0] mem [MEM_WORDS];
  logic [IDXW-1:0]  reqIdx;
  logic             rdHit;
  logic [WIDTH-1:0] rdData;
  logic             drain;
  logic [IDXW-1:0]  headIdx;
  logic [WIDTH-1:0] headData;
  logic             full;
  logic [CW-1:0]    count;
  logic             unusedAddrBits;

  assign reqIdx         = bus.aluResultM[IDXW+1:2];
  assign unusedAddrBits = ^{bus.aluResultM[1:0], bus.aluResultM[WIDTH-1:IDXW+2], full};

  wbuf_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) uFifo (
    .clk      (clk),
    .reset    (reset),
    .wrEn     (bus.memWriteM),
    .wrIdx    (reqIdx),
    .wrData   (bus.writeData),
    .rdIdx    (reqIdx),
    .rdHit    (rdHit),
    .rdData   (rdData),
    .drain    (drain),
    .headIdx  (headIdx),
    .headData (headData),
    .full     (full),
    .count    (count)
  );

  // Retire the head entry into RAM; RAM contents are never reset.
  always_ff @(posedge clk) begin
    if (drain) mem[headIdx] <= headData;
  end

  assign bus.readDataM = rdHit ? rdData : mem[reqIdx];
  assign bus.wbufCount = count;
  assign bus.wbufEmpty = (count == '0);

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf (DEPTH=4, MEM_WORDS=64).
// Honors DMEM_WBUF_COALESCE_EN for the duplicate-store occupancy check.
module tb_dmem_wbuf;

  logic clk;
  logic reset;
  int   nCmp  = 0;
  int   nFail = 0;

  dmem_wbuf_if #(.WIDTH(32), .DEPTH(4)) bus ();

  dmem_wbuf #(.WIDTH(32), .DEPTH(4), .MEM_WORDS(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
    bus.memWriteM  = we;
    bus.aluResultM = addr;
    bus.writeData  = data;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.memWriteM  = 1'b0;
    bus.aluResultM = '0;
    bus.writeData  = '0;
    tick();
    tick();
    reset = 1'b0;

    // Preload RAM through the buffer: 0x10 and 0x30/0x34/0x38, drained fully.
    drive(1'b1, 32'h10, 32'h5555AAAA); tick();
    drive(1'b1, 32'h30, 32'h11110000); tick();
    drive(1'b1, 32'h34, 32'h11110001); tick();
    drive(1'b1, 32'h38, 32'h11110002); tick();
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) tick();

    // Reset, then idle read of 0x10 comes from RAM.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h10, 32'h0);
    check("rst_empty", {31'b0, bus.wbufEmpty}, 32'd1);
    check("rst_count", {29'b0, bus.wbufCount}, 32'd0);
    check("rst_read",  bus.readDataM, 32'h5555AAAA);

    // Single store: invisible same cycle, forwarded next cycle, then drained.
    drive(1'b1, 32'h10, 32'hAAAA0001);
    check("st_samecycle", bus.readDataM, 32'h5555AAAA);
    tick();
    drive(1'b0, 32'h10, 32'h0);
    check("st_fwd",       bus.readDataM, 32'hAAAA0001);
    check("st_fwd_count", {29'b0, bus.wbufCount}, 32'd1);
    tick();
    check("st_drain_count", {29'b0, bus.wbufCount}, 32'd0);
    check("st_drain_empty", {31'b0, bus.wbufEmpty}, 32'd1);
    check("st_ram_read",    bus.readDataM, 32'hAAAA0001);

    // Five back-to-back stores into a 4-entry buffer.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(i * 4), 32'hB0000000 + 32'(i));
      tick();
      check($sformatf("fill_count%0d", i), {29'b0, bus.wbufCount}, (i < 3) ? 32'(i + 1) : 32'd4);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'(i * 4), 32'h0);
      check($sformatf("fill_read%0d", i), bus.readDataM, 32'hB0000000 + 32'(i));
    end
    for (int i = 0; i < 4; i++) tick();
    check("fill_empty", {31'b0, bus.wbufEmpty}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'(i * 4), 32'h0);
      check($sformatf("fill_ram%0d", i), bus.readDataM, 32'hB0000000 + 32'(i));
    end

    // Duplicate index: youngest data wins.
    drive(1'b1, 32'h20, 32'd1); tick();
    drive(1'b1, 32'h20, 32'd2); tick();
    drive(1'b0, 32'h20, 32'h0);
    check("dup_fwd", bus.readDataM, 32'd2);
`ifdef DMEM_WBUF_COALESCE_EN
    check("dup_count", {29'b0, bus.wbufCount}, 32'd1);
`else
    check("dup_count", {29'b0, bus.wbufCount}, 32'd2);
`endif
    tick();
    tick();
    check("dup_empty", {31'b0, bus.wbufEmpty}, 32'd1);
    check("dup_ram",   bus.readDataM, 32'd2);

    // Asynchronous reset with three stores pending discards them.
    drive(1'b1, 32'h30, 32'hDEAD0000); tick();
    drive(1'b1, 32'h34, 32'hDEAD0001); tick();
    drive(1'b1, 32'h38, 32'hDEAD0002); tick();
    drive(1'b0, 32'h30, 32'h0);
    check("pend_count", {29'b0, bus.wbufCount}, 32'd3);
    check("pend_fwd",   bus.readDataM, 32'hDEAD0000);
    reset = 1'b1;
    #1;
    check("arst_count", {29'b0, bus.wbufCount}, 32'd0);
    check("arst_empty", {31'b0, bus.wbufEmpty}, 32'd1);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h30 + 32'(i * 4), 32'h0);
      check($sformatf("arst_ram%0d", i), bus.readDataM, 32'h11110000 + 32'(i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
